// File: rtl/post_code_pkg.sv
// Shared types and constants for the POST debug-port responder.
// The FSM state encoding is visible to the bench through o_dbg_state.
package post_code_pkg;

  localparam int BREAK_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/post_code_sync.sv
// testreq synchronizer, rising-edge detector and break (request-idle) timer.
// o_brk stays high while the idle count sits at its saturation value.
module post_code_sync
  import post_code_pkg::*;
#(
  parameter int BREAK_CYCLES = BREAK_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_testreq,
  output logic o_req_pulse,
  output logic o_brk
);

  localparam int CW = $clog2(BREAK_CYCLES + 1);
  localparam logic [CW-1:0] BRK_MAX = CW'(BREAK_CYCLES);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_brk_cnt;
  logic          w_pulse;

  assign w_pulse = r_s1 & ~r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_brk_cnt <= '0;
    end else begin
      r_s1 <= i_testreq;
      r_s2 <= r_s1;
      if (w_pulse) begin
        r_brk_cnt <= '0;
      end else if (r_brk_cnt != BRK_MAX) begin
        r_brk_cnt <= r_brk_cnt + CW'(1);
      end
    end
  end

  assign o_req_pulse = w_pulse;
  assign o_brk       = (r_brk_cnt == BRK_MAX);

endmodule

// File: rtl/post_code.sv
// POST debug-port target responder: FSM, serial byte shifter and testack mux.
// Define POST_CODE_CHAIN_EN to chain bytes (P1 after the 8th data bit) instead of stopping in DONE.
module post_code
  import post_code_pkg::*;
#(
  parameter int BREAK_CYCLES = BREAK_CYCLES_DEF
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       testreq,
  output logic       testack,
  input  logic [7:0] txin,
  input  logic       tx_pending,
  output logic       want_tx,
  output logic [2:0] o_dbg_state
);

`ifdef POST_CODE_CHAIN_EN
  localparam state_t BYTE_END_STATE = P1;
`else
  localparam state_t BYTE_END_STATE = DONE;
`endif

  // Byte source handshake: tx_pending is "valid" for txin; want_tx is a
  // one-cycle "taken" strobe in the first DATA cycle, after which the source may reload txin.
  state_t     r_state;
  state_t     w_base_state;
  state_t     w_next_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;
  logic       r_want_tx;
  logic       w_pulse;
  logic       w_brk;
  logic       w_load;
  logic       w_shift;

  post_code_sync #(
    .BREAK_CYCLES(BREAK_CYCLES)
  ) u_sync (
    .i_clk      (refclk),
    .i_rst      (reset),
    .i_testreq  (testreq),
    .o_req_pulse(w_pulse),
    .o_brk      (w_brk)
  );

  always_ff @(posedge refclk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A break lands first, so a coincident pulse is processed from IDLE.
  always_comb begin
    w_base_state = w_brk ? IDLE : r_state;
    w_next_state = w_base_state;
    if (w_pulse) begin
      case (w_base_state)
        IDLE:    w_next_state = P1;
        P1:      w_next_state = P2;
        P2:      w_next_state = P3;
        P3:      w_next_state = tx_pending ? DATA : P1;
        DATA:    w_next_state = (r_bitcnt == 3'd7) ? BYTE_END_STATE : DATA;
        DONE:    w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign w_load  = w_pulse && (w_base_state == P3) && tx_pending;
  assign w_shift = w_pulse && (w_base_state == DATA);

  always_ff @(posedge refclk) begin
    if (reset) begin
      r_shreg   <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_want_tx <= 1'b0;
    end else begin
      r_want_tx <= w_load;
      if (w_load) begin
        r_shreg  <= txin;
        r_bitcnt <= 3'd0;
      end else if (w_shift) begin
        r_shreg  <= {r_shreg[6:0], 1'b0};
        r_bitcnt <= r_bitcnt + 3'd1;
      end else if (w_brk) begin
        r_bitcnt <= 3'd0;
      end
    end
  end

  // testack already carries the answer for the next pulse before it rises.
  always_comb begin
    testack = 1'b0;
    case (r_state)
      P3:      testack = tx_pending;
      DATA:    testack = r_shreg[7];
      default: testack = 1'b0;
    endcase
  end

  assign want_tx     = r_want_tx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_post_code.sv
// Directed self-checking bench for post_code; 2 MHz refclk, host pulses 1 us high / 1 us low.
`timescale 1ns/1ps
module tb_post_code;
  import post_code_pkg::*;

  logic       refclk;
  logic       reset;
  logic       testreq;
  logic       testack;
  logic [7:0] txin;
  logic       tx_pending;
  logic       want_tx;
  logic [2:0] o_dbg_state;

  int checks;
  int failures;
  int want_cnt;

  post_code dut (
    .refclk     (refclk),
    .reset      (reset),
    .testreq    (testreq),
    .testack    (testack),
    .txin       (txin),
    .tx_pending (tx_pending),
    .want_tx    (want_tx),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  initial begin
    refclk = 1'b0;
    forever #250 refclk = ~refclk;
  end

  always @(negedge refclk) begin
    if (want_tx === 1'b1) want_cnt++;
  end

  // driver tasks
  task automatic do_pulse(output logic ack);
    @(negedge refclk);
    ack = testack;
    testreq = 1'b1;
    repeat (2) @(negedge refclk);
    testreq = 1'b0;
    @(negedge refclk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    testreq = 1'b0;
    tx_pending = 1'b0;
    txin = 8'h00;
    idle_cycles(4);
    reset = 1'b0;
    checks++;
    if (testack !== 1'b0) begin
      failures++;
      $display("FAIL reset_testack: got %b expected 0", testack);
    end
    checks++;
    if (want_tx !== 1'b0) begin
      failures++;
      $display("FAIL reset_want_tx: got %b expected 0", want_tx);
    end
    checks++;
    if (o_dbg_state !== 3'(IDLE)) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, 3'(IDLE));
    end
  endtask

  task automatic test_no_pending();
    logic ack;
    tx_pending = 1'b0;
    want_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        do_pulse(ack);
        checks++;
        if (ack !== 1'b0) begin
          failures++;
          $display("FAIL no_pending round%0d ack[%0d]: got %b expected 0", r, i, ack);
        end
      end
      if (r == 0) idle_cycles(60);
    end
    checks++;
    if (o_dbg_state !== 3'(P1)) begin
      failures++;
      $display("FAIL no_pending_state: got %0d expected %0d", o_dbg_state, 3'(P1));
    end
    checks++;
    if (want_cnt !== 0) begin
      failures++;
      $display("FAIL no_pending_want_tx: got %0d cycles expected 0", want_cnt);
    end
  endtask

  task automatic test_single_byte();
    logic       ack;
    logic [7:0] b;
    logic [3:0] cmd;
    idle_cycles(60);
    b = 8'h5A;
    cmd = 4'b0001;
    txin = b;
    tx_pending = 1'b1;
    want_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      logic e;
      e = (i < 4) ? cmd[3-i] : b[11-i];
      do_pulse(ack);
      checks++;
      if (ack !== e) begin
        failures++;
        $display("FAIL single_byte ack[%0d]: got %b expected %b", i, ack, e);
      end
    end
    checks++;
    if (want_cnt !== 1) begin
      failures++;
      $display("FAIL single_byte_want_tx: got %0d cycles expected 1", want_cnt);
    end
`ifdef POST_CODE_CHAIN_EN
    checks++;
    if (o_dbg_state !== 3'(P1)) begin
      failures++;
      $display("FAIL single_byte_end_state: got %0d expected %0d", o_dbg_state, 3'(P1));
    end
`else
    checks++;
    if (o_dbg_state !== 3'(DONE)) begin
      failures++;
      $display("FAIL single_byte_end_state: got %0d expected %0d", o_dbg_state, 3'(DONE));
    end
`endif
  endtask

`ifdef POST_CODE_CHAIN_EN
  task automatic test_chain();
    logic       ack;
    logic [7:0] b;
    logic [2:0] hdr;
    int         n;
    idle_cycles(60);
    tx_pending = 1'b0;
    for (int i = 0; i < 4; i++) do_pulse(ack);
    b = 8'h5A;
    hdr = 3'b001;
    txin = b;
    tx_pending = 1'b1;
    want_cnt = 0;
    n = 0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 11; i++) begin
        logic e;
        e = (i < 3) ? hdr[2-i] : b[10-i];
        do_pulse(ack);
        n++;
        checks++;
        if (ack !== e) begin
          failures++;
          $display("FAIL chain g%0d ack[%0d]: got %b expected %b", g, i, ack, e);
        end
      end
    end
    checks++;
    if (want_cnt !== 5 || n !== 55) begin
      failures++;
      $display("FAIL chain_count: got want=%0d pulses=%0d expected want=5 pulses=55", want_cnt, n);
    end
    idle_cycles(50);
    checks++;
    if (o_dbg_state !== 3'(IDLE)) begin
      failures++;
      $display("FAIL chain_break_state: got %0d expected %0d", o_dbg_state, 3'(IDLE));
    end
  endtask
`else
  task automatic test_done_mode();
    logic       ack;
    logic [7:0] b;
    logic [3:0] cmd;
    idle_cycles(60);
    b = 8'hA5;
    cmd = 4'b0001;
    txin = b;
    tx_pending = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic e;
      e = (i < 4) ? cmd[3-i] : ((i < 12) ? b[11-i] : 1'b0);
      do_pulse(ack);
      checks++;
      if (ack !== e) begin
        failures++;
        $display("FAIL done_mode ack[%0d]: got %b expected %b", i, ack, e);
      end
    end
    idle_cycles(60);
    for (int i = 0; i < 4; i++) begin
      do_pulse(ack);
      checks++;
      if (ack !== cmd[3-i]) begin
        failures++;
        $display("FAIL done_mode_rearm ack[%0d]: got %b expected %b", i, ack, cmd[3-i]);
      end
    end
  endtask
`endif

  task automatic test_break_mid_byte();
    logic       ack;
    logic [7:0] b;
    logic [3:0] cmd;
    idle_cycles(60);
    b = 8'hC3;
    cmd = 4'b0001;
    txin = b;
    tx_pending = 1'b1;
    for (int i = 0; i < 7; i++) begin
      logic e;
      e = (i < 4) ? cmd[3-i] : b[11-i];
      do_pulse(ack);
      checks++;
      if (ack !== e) begin
        failures++;
        $display("FAIL break_mid ack[%0d]: got %b expected %b", i, ack, e);
      end
    end
    idle_cycles(40);
    checks++;
    if (o_dbg_state !== 3'(IDLE)) begin
      failures++;
      $display("FAIL break_mid_state: got %0d expected %0d", o_dbg_state, 3'(IDLE));
    end
    for (int i = 0; i < 4; i++) begin
      do_pulse(ack);
      checks++;
      if (ack !== cmd[3-i]) begin
        failures++;
        $display("FAIL break_mid_rearm ack[%0d]: got %b expected %b", i, ack, cmd[3-i]);
      end
    end
  endtask

  task automatic test_reset_in_data();
    logic ack;
    idle_cycles(60);
    txin = 8'hA5;
    tx_pending = 1'b1;
    for (int i = 0; i < 4; i++) do_pulse(ack);
    checks++;
    if (testack !== 1'b1 || o_dbg_state !== 3'(DATA)) begin
      failures++;
      $display("FAIL pre_reset_data: got ack=%b state=%0d expected ack=1 state=%0d",
               testack, o_dbg_state, 3'(DATA));
    end
    reset = 1'b1;
    @(negedge refclk);
    reset = 1'b0;
    checks++;
    if (testack !== 1'b0 || o_dbg_state !== 3'(IDLE)) begin
      failures++;
      $display("FAIL reset_in_data: got ack=%b state=%0d expected ack=0 state=%0d",
               testack, o_dbg_state, 3'(IDLE));
    end
    do_pulse(ack);
    checks++;
    if (ack !== 1'b0 || o_dbg_state !== 3'(P1)) begin
      failures++;
      $display("FAIL reset_in_data_first_pulse: got ack=%b state=%0d expected ack=0 state=%0d",
               ack, o_dbg_state, 3'(P1));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    want_cnt = 0;
    test_reset();
    test_no_pending();
    test_single_byte();
`ifdef POST_CODE_CHAIN_EN
    test_chain();
`else
    test_done_mode();
`endif
    test_break_mid_byte();
    test_reset_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/post_code.md
# post_code

Target-side responder for the host's two-wire POST debug port (host-driven `testreq`, pod-driven `testack`). It counts host request pulses and answers each one on `testack`, including the status bits and serial bytes of the INPUT command. It sits between the POST connector and a local byte source. A request-idle period (break) returns it to its start state.

## Interface
- `BREAK_CYCLES`, default 32: count of `refclk` cycles with no `testreq` rising edge that constitutes a break (16 µs at 2 MHz).
- `refclk`  in  1  2 MHz system clock; every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `testreq`  in  1  host request strobe, asynchronous to `refclk`.
- `testack`  out  1  acknowledge/data bit to the host.
- `txin`  in  8  byte to send to the host, MSB first.
- `tx_pending`  in  1  `txin` holds a valid byte.
- `want_tx`  out  1  one-cycle strobe: `txin` has been captured and the source may load the next byte.

## Operation
- `testreq` passes through one metastability flop `s1` and one history flop `s2`.
  - Pulse event: `s1 & !s2`.
  - Only rising edges advance the FSM.
- FSM states and the `testack` value each presents for the next pulse:
  - IDLE: 0.
  - P1: 0.
  - P2: OUTPUT-ready, which is constant 0 because there is no OUTPUT path.
  - P3: `tx_pending`.
  - DATA: `shreg[7]`.
  - DONE: 0.
- `testack` is combinational from the state register, `shreg` and `tx_pending`. It therefore already holds the answer to pulse n when pulse n rises.
- Transitions on a pulse event:
  - IDLE→P1, P1→P2, P2→P3.
  - P3 with `tx_pending`=1:
    - `shreg <= txin`; `bitcnt <= 0`; `want_tx` high for one cycle.
    - Next state DATA.
  - P3 with `tx_pending`=0: next state P1, so the host re-polls with three pulses (0, x, y).
  - DATA: `shreg <= shreg<<1`; `bitcnt++`. On the 8th data pulse the next state is P1 when chained, otherwise DONE.
  - DONE: pulses are ignored and `testack`=0.
- Resulting host view:
  - First command: acks 0, 0, x, y.
  - After y=1: 8 data bits.
  - Each further byte when chained: 0, x, y, then 8 data bits, i.e. 11 pulses per byte.
- Break timer:
  - The counter clears on every pulse event and otherwise increments, saturating at `BREAK_CYCLES`.
  - On reaching `BREAK_CYCLES` the state is forced to IDLE and `bitcnt` to 0.
  - If a pulse event lands in the same cycle the break reaches `BREAK_CYCLES`, the break is applied first and then the pulse is processed from IDLE, giving P1.
- `tx_pending` dropping during DATA does not abort the byte; `shreg` is already latched.

## Timing
- Reset values:
  - State IDLE; `shreg` 0; `bitcnt` 0; break counter 0.
  - `testack` 0; `want_tx` 0; `s1`/`s2` 0.
- Reset mid-byte aborts the byte; the next pulse is treated as command position 1.
- Latency: the state and `testack` update on the 2nd `refclk` rising edge after `testreq` rises, which is at most 1000 ns later.
- Host constraints:
  - `testreq` high and low times ≥ 500 ns.
  - Request period ≥ 1 µs.
  - `testack` is sampled near the `testreq` rising edge.
- `want_tx` is asserted in the same cycle the FSM leaves P3 for DATA.

## Configuration
- `POST_CODE_CHAIN_EN` defined: after the 8th data bit the FSM goes to P1, so bytes chain without a break.
- `POST_CODE_CHAIN_EN` undefined: after the 8th data bit the FSM goes to DONE, and a break is required before the next command.

## Structure
- Package `post_code_pkg`: state enum (IDLE, P1, P2, P3, DATA, DONE) and the default `BREAK_CYCLES` constant.
- Sub-module `post_code_sync`:
  - Contains the `testreq` synchronizer, rising-edge detect and break counter.
  - Outputs `req_pulse` and `brk`.
- The top level holds the FSM, `shreg`, `bitcnt` and the `testack` mux.

## Test plan
- Reset, then 4 pulses + 30 µs break, then 4 pulses with `tx_pending`=0 → acks 0, 0, 0, 0; `want_tx` never asserted.
- `tx_pending`=1, `txin`=0x5A, then 4 pulses + 8 pulses → acks 0, 0, 0, 1, then 0, 1, 0, 1, 1, 0, 1, 0; `want_tx` exactly one cycle.
- Chained (macro defined): after a y=0 command, 5 × 11 pulses with `txin`=0x5A → last 8 acks of each group are 0x5A; 55 pulses total; 25 µs break afterwards returns to IDLE.
- Macro undefined: after one 0xA5 byte, 5 more pulses → all ack 0; break then 4 pulses → 0, 0, 0, y.
- Break mid-byte: 3 data bits then 20 µs idle → next 4 pulses give 0, 0, 0, y.
- Reset asserted for one cycle in DATA → `testack` 0 and state IDLE on the next cycle.
